alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Command-side neighbour stage of the 4-bit ALU. It accepts operation requests (A, B, sel) over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It issues one command at a time to the ALU's operand and select inputs, then captures the ALU's registered 6-bit Result one cycle later. The captured result is presented on a valid/ready response port, in command order.

Parameters:
DEPTH, 4, command FIFO entries; power of two, minimum 2.
OPW, 4, operand width; must match ALU A/B.
RESW, 6, result width; must match ALU Result.

Ports:
clk  in  1  rising-edge clock, shared with the ALU.
reset  in  1  asynchronous active-low reset (0 = reset asserted). The ALU's active-high reset is driven from ~reset at the top level.
cmd_valid  in  1  command offered.
cmd_ready  out  1  FIFO can accept a command.
cmd_a  in  OPW  operand A.
cmd_b  in  OPW  operand B.
cmd_sel  in  3  ALU opcode.
alu_a  out  OPW  registered, drives ALU A.
alu_b  out  OPW  registered, drives ALU B.
alu_sel  out  3  registered, drives ALU sel.
alu_result  in  RESW  ALU Result.
rsp_valid  out  1  response held.
rsp_ready  in  1  consumer accepts response.
rsp_result  out  RESW  captured result.
rsp_sel  out  3  opcode of the captured result.
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
busy  out  1  high when FSM is not IDLE or fifo_count is not 0.

Behaviour:
- Reset values (asynchronous on reset=0):
  - FIFO empty, pointers 0, fifo_count 0.
  - State IDLE.
  - alu_a, alu_b, alu_sel = 0.
  - rsp_valid = 0, rsp_result = 0, rsp_sel = 0.
  - cmd_ready = 1 on the first cycle after release.
- Reset mid-operation discards all queued and in-flight commands. No response is emitted for them.
- Push: on a clk edge with cmd_valid & cmd_ready. cmd_ready = (fifo_count != DEPTH), registered-state only, with no combinational path from rsp_ready or pop.
- Full: cmd_ready = 0. cmd_valid is ignored; no overwrite.
- Simultaneous push and pop on the same edge: fifo_count is unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into alu_a/alu_b/alu_sel and go to ISSUE. Otherwise stay.
  - ISSUE: ALU inputs are stable; the ALU samples them at the end of this cycle. Go to WAIT unconditionally.
  - WAIT: alu_result is valid. On the edge, capture alu_result into rsp_result and alu_sel into rsp_sel, set rsp_valid = 1, go to HOLD.
  - HOLD: rsp_valid = 1, rsp_result and rsp_sel stable. On rsp_ready: clear rsp_valid. If the FIFO is non-empty on that edge, pop the next command into alu_* and go to ISSUE (back-to-back). Otherwise go to IDLE.
- Latency: a command accepted at edge T into an empty, IDLE block is popped at T+1, captured at T+3. rsp_valid is high from the cycle after edge T+3.
- Throughput: one response per 3 cycles with rsp_ready held at 1.
- alu_* hold their last values when not issuing; they do not return to 0.
- Ordering: strict FIFO order. No response is dropped or duplicated under any rsp_ready pattern.
- A command pushed on the same edge the FSM pops from an empty FIFO is not visible until the next cycle. There is no FIFO bypass.

Optional Feature:
ALU_RESULT_MASK_EN:
- Defined: for logical opcodes (010 and, 011 or, 101 xor, 110 nand, 111 nor), rsp_result[RESW-1:OPW] is forced to 0 at capture. This removes the upper ones the ALU produces for nand/nor. Arithmetic opcodes (000, 001, 100) are passed unmodified.
- Undefined: alu_result is captured raw for all opcodes.

Test Plan:
- Single add: after reset, push A=9, B=8, sel=000 at edge T -> alu_a=9 at T+1, rsp_valid at T+3 with rsp_result=6'h11, rsp_sel=000.
- Sub wrap and multiply truncation: push (3,5,001) then (15,15,100), rsp_ready=1 -> responses 6'h3E then 6'h21, in order, 3 cycles apart.
- Full/backpressure: rsp_ready=0, push 6 commands with DEPTH=4 -> cmd_ready=0 once fifo_count=4. Exactly 5 commands accepted (4 queued + 1 held). Releasing rsp_ready drains all 5 in order.
- Simultaneous push/pop: fifo_count=2 in HOLD, rsp_ready=1 and cmd_valid=1 on the same edge -> fifo_count stays 2, next command issued.
- Mask feature: push A=F, B=F, sel=110 -> rsp_result=6'h30 without ALU_RESULT_MASK_EN, 6'h00 with it.
- Reset mid-operation: assert reset in WAIT with 3 queued -> immediately rsp_valid=0, fifo_count=0, alu_*=0. No response after release.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: bundle of the command, ALU-side and response signals of the sequencer
// slave  : sequencer view (accepts cmd_*, drives alu_*, presents rsp_*, status fifo_count/busy)
// master : environment view (offers cmd_*, returns alu_result, consumes rsp_*)
interface alu_cmd_sequencer_if #(
  parameter int DEPTH = 4,
  parameter int OPW   = 4,
  parameter int RESW  = 6
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [OPW-1:0]  cmd_a;
  logic [OPW-1:0]  cmd_b;
  logic [2:0]      cmd_sel;
  logic [OPW-1:0]  alu_a;
  logic [OPW-1:0]  alu_b;
  logic [2:0]      alu_sel;
  logic [RESW-1:0] alu_result;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [RESW-1:0] rsp_result;
  logic [2:0]      rsp_sel;
  logic [CW-1:0]   fifo_count;
  logic            busy;
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, alu_result, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_sel, fifo_count, busy
  );
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, alu_result, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_sel, fifo_count, busy
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands in a FIFO, issues them one at a time and returns results in order
// Ports: clk, reset (async active-low), bus (alu_cmd_sequencer_if.slave: cmd_*, alu_*, rsp_*, fifo_count, busy)
// Optional: define ALU_RESULT_MASK_EN to zero the upper result bits of logical opcodes at capture
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int OPW   = 4,
  parameter int RESW  = 6
) (
  input logic               clk,
  input logic               reset,
  alu_cmd_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * OPW + 3;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t          state_q, state_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic [OPW-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]      alu_sel_q, alu_sel_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [RESW-1:0] rsp_result_q, rsp_result_d;
  logic [2:0]      rsp_sel_q, rsp_sel_d;
  logic            push, pop, empty;
  logic [RESW-1:0] cap_result;
  assign empty         = count_q == '0;
  assign bus.cmd_ready = count_q != (AW+1)'(DEPTH);
  assign push          = bus.cmd_valid & bus.cmd_ready;
`ifdef ALU_RESULT_MASK_EN
  logic logic_op;
  assign logic_op   = !(alu_sel_q inside {3'b000, 3'b001, 3'b100});
  assign cap_result = logic_op ? {{(RESW-OPW){1'b0}}, bus.alu_result[OPW-1:0]} : bus.alu_result;
`else
  assign cap_result = bus.alu_result;
`endif
  // pop decisions use registered occupancy only, so a same-edge push is never bypassed
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_sel_d    = rsp_sel_q;
    case (state_q)
      IDLE: begin
        pop     = !empty;
        state_d = empty ? IDLE : ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        rsp_valid_d  = 1'b1;
        rsp_result_d = cap_result;
        rsp_sel_d    = alu_sel_q;
        state_d      = HOLD;
      end
      HOLD: if (bus.rsp_ready) begin
        rsp_valid_d = 1'b0;
        pop         = !empty;
        state_d     = empty ? IDLE : ISSUE;
      end
      default: state_d = IDLE;
    endcase
    if (pop) {alu_a_d, alu_b_d, alu_sel_d} = mem_q[rd_ptr_q];
  end
  assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.cmd_a, bus.cmd_b, bus.cmd_sel};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_sel_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_q + AW'(push);
      rd_ptr_q     <= rd_ptr_q + AW'(pop);
      count_q      <= count_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_sel_q    <= rsp_sel_d;
    end
  end
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_sel    = rsp_sel_q;
  assign bus.fifo_count = count_q;
  assign bus.busy       = state_q != IDLE || !empty;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed and randomized checks of alu_cmd_sequencer against a queue-based reference
module tb_alu_cmd_sequencer;
  localparam int DEPTH = 4, OPW = 4, RESW = 6;
`ifdef ALU_RESULT_MASK_EN
  localparam logic [5:0] NAND_FF = 6'h00;
`else
  localparam logic [5:0] NAND_FF = 6'h30;
`endif
  typedef struct packed {logic [3:0] a; logic [3:0] b; logic [2:0] sel;} cmd_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] alu_res;
  int checks = 0, failures = 0, rsp_seen = 0;
  cmd_t exp_q[$];
  alu_cmd_sequencer_if #(.DEPTH(DEPTH), .OPW(OPW), .RESW(RESW)) bus ();
  alu_cmd_sequencer #(.DEPTH(DEPTH), .OPW(OPW), .RESW(RESW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [5:0] alu_ref(logic [3:0] a, logic [3:0] b, logic [2:0] s);
    int x = int'(a), y = int'(b), r;
    case (s)
      3'd0: r = x + y;
      3'd1: r = x - y;
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x * y;
      3'd5: r = x ^ y;
      3'd6: r = ~(x & y);
      default: r = ~(x | y);
    endcase
    return r[5:0];
  endfunction
  function automatic logic [5:0] exp_result(cmd_t c);
    logic [5:0] r = alu_ref(c.a, c.b, c.sel);
`ifdef ALU_RESULT_MASK_EN
    if (!(c.sel inside {3'b000, 3'b001, 3'b100})) r[5:4] = 2'b00;
`endif
    return r;
  endfunction
  always @(posedge clk or negedge reset)
    if (!reset) alu_res <= '0;
    else alu_res <= alu_ref(bus.alu_a, bus.alu_b, bus.alu_sel);
  assign bus.alu_result = alu_res;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic c_hs, r_hs;
    cmd_t c, e;
    logic [5:0] r;
    logic [2:0] s;
    c_hs = bus.cmd_valid && bus.cmd_ready;
    r_hs = bus.rsp_valid && bus.rsp_ready;
    c = '{bus.cmd_a, bus.cmd_b, bus.cmd_sel};
    r = bus.rsp_result;
    s = bus.rsp_sel;
    @(posedge clk);
    #1;
    if (r_hs) begin
      rsp_seen++;
      check("rsp_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_rsp_result", r, exp_result(e));
        check("sb_rsp_sel", s, e.sel);
      end
    end
    if (c_hs) exp_q.push_back(c);
  endtask
  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    bit acc = 0;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_sel = s;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("push_accepted", acc, 1);
  endtask
  task automatic drain();
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.busy || bus.rsp_valid); i++) tick();
    bus.rsp_ready = 1'b0;
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_busy", bus.busy, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n_acc, n;
    bit ok;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_sel = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_fifo_count", bus.fifo_count, 0);
    reset = 1'b1;
    check("rel_cmd_ready", bus.cmd_ready, 1);
    check("rel_alu_a", bus.alu_a, 0);
    check("rel_alu_b", bus.alu_b, 0);
    check("rel_alu_sel", bus.alu_sel, 0);
    check("rel_rsp_result", bus.rsp_result, 0);
    check("rel_rsp_sel", bus.rsp_sel, 0);
    check("rel_busy", bus.busy, 0);
    // single add: accepted at T
    push(4'd9, 4'd8, 3'b000);
    check("add_count_T", bus.fifo_count, 1);
    tick();
    check("add_alu_a_T1", bus.alu_a, 9);
    check("add_alu_b_T1", bus.alu_b, 8);
    check("add_fifo_T1", bus.fifo_count, 0);
    tick();
    check("add_rsp_valid_T2", bus.rsp_valid, 0);
    tick();
    check("add_rsp_valid_T3", bus.rsp_valid, 1);
    check("add_rsp_result", bus.rsp_result, 6'h11);
    check("add_rsp_sel", bus.rsp_sel, 0);
    tick();
    check("add_hold_no_ready", bus.rsp_valid, 1);
    drain();
    // sub wrap then multiply truncation, back-to-back
    bus.rsp_ready = 1'b1;
    push(4'd3, 4'd5, 3'b001);
    push(4'd15, 4'd15, 3'b100);
    tick();
    tick();
    check("sub_rsp_valid", bus.rsp_valid, 1);
    check("sub_rsp_result", bus.rsp_result, 6'h3E);
    check("sub_rsp_sel", bus.rsp_sel, 1);
    tick();
    check("mul_gap_valid", bus.rsp_valid, 0);
    check("mul_issued_a", bus.alu_a, 15);
    tick();
    check("mul_gap_valid2", bus.rsp_valid, 0);
    tick();
    check("mul_rsp_valid", bus.rsp_valid, 1);
    check("mul_rsp_result", bus.rsp_result, 6'h21);
    check("mul_rsp_sel", bus.rsp_sel, 4);
    drain();
    // full / backpressure
    bus.rsp_ready = 1'b0;
    n_acc = 0;
    bus.cmd_a = 4'($urandom);
    bus.cmd_b = 4'($urandom);
    bus.cmd_sel = 3'($urandom);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ok = bus.cmd_ready;
      tick();
      if (ok) begin
        n_acc++;
        bus.cmd_a = 4'($urandom);
        bus.cmd_b = 4'($urandom);
        bus.cmd_sel = 3'($urandom);
      end
    end
    bus.cmd_valid = 1'b0;
    check("full_accepted", n_acc, 5);
    check("full_cmd_ready", bus.cmd_ready, 0);
    check("full_fifo_count", bus.fifo_count, 4);
    check("full_rsp_valid", bus.rsp_valid, 1);
    n = rsp_seen;
    drain();
    check("full_drained", rsp_seen - n, 5);
    // simultaneous push/pop in HOLD with two queued
    push(4'd1, 4'd1, 3'b000);
    push(4'd2, 4'd2, 3'b011);
    push(4'd3, 4'd3, 3'b101);
    tick();
    check("pp_fifo_before", bus.fifo_count, 2);
    check("pp_rsp_valid_before", bus.rsp_valid, 1);
    bus.cmd_a = 4'd4;
    bus.cmd_b = 4'd4;
    bus.cmd_sel = 3'b010;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("pp_fifo_after", bus.fifo_count, 2);
    check("pp_rsp_valid_after", bus.rsp_valid, 0);
    check("pp_next_alu_a", bus.alu_a, 2);
    check("pp_next_alu_sel", bus.alu_sel, 3'b011);
    drain();
    // nand upper bits
    push(4'hF, 4'hF, 3'b110);
    tick();
    tick();
    tick();
    check("nand_rsp_valid", bus.rsp_valid, 1);
    check("nand_rsp_result", bus.rsp_result, NAND_FF);
    drain();
    // reset while a command is in WAIT with three queued
    for (int i = 0; i < 5; i++) push(4'(i + 1), 4'(i), 3'(i));
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    check("mid_fifo_count", bus.fifo_count, 3);
    check("mid_rsp_valid", bus.rsp_valid, 0);
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_fifo_count", bus.fifo_count, 0);
    check("mid_rst_alu_a", bus.alu_a, 0);
    check("mid_rst_alu_b", bus.alu_b, 0);
    check("mid_rst_alu_sel", bus.alu_sel, 0);
    tick();
    tick();
    reset = 1'b1;
    check("mid_rel_cmd_ready", bus.cmd_ready, 1);
    n = rsp_seen;
    repeat (10) tick();
    check("mid_no_rsp", rsp_seen - n, 0);
    check("mid_busy", bus.busy, 0);
    bus.rsp_ready = 1'b0;
    // randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      bus.cmd_valid = $urandom_range(0, 9) < 6;
      bus.cmd_a = 4'($urandom);
      bus.cmd_b = 4'($urandom);
      bus.cmd_sel = 3'($urandom);
      bus.rsp_ready = $urandom_range(0, 1) == 1;
      n = exp_q.size();
      ok = int'(bus.fifo_count) <= n && n - int'(bus.fifo_count) <= 1 &&
           (!bus.rsp_valid || n - int'(bus.fifo_count) == 1);
      check("rnd_occupancy", ok, 1);
      check("rnd_cmd_ready", bus.cmd_ready, 32'(int'(bus.fifo_count) != DEPTH));
      tick();
    end
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
